// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared operation codes, FSM states and op classification for
//               the sequential ALU. SEQ_ALU_FAST_MUL_EN moves MUL/MULH onto
//               the single-cycle path.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_EQ   = 4'b1000,
        OP_SLT  = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_MULH = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_REM  = 4'b1110,
        OP_REMU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // True for ops that run through the multi-cycle engine
    function automatic logic is_iterative(input alu_op_e op);
`ifdef SEQ_ALU_FAST_MUL_EN
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`else
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_divmul.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_divmul
// Description : Iterative shift-add multiplier / restoring divider. One bit
//               per step; the final step presents the sign-corrected result
//               combinationally on o-side result while last is high.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_divmul
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int W     = DATA_WIDTH;

    logic [W-1:0]     acc_q, acc_d, qr_q, qr_d, m_q, m_d;
    alu_op_e          op_q, op_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_signed, w_a_neg, w_b_neg, w_is_div, w_div_ge;
    logic [W-1:0]     w_mag_a, w_mag_b, w_acc_n, w_qr_n, w_div_diff;
    logic [W:0]       w_mul_sum, w_div_sh;
    logic [2*W-1:0]   w_prod, w_prod_fix;

    assign last = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // One iteration of both algorithms plus the final sign fix-up
    always_comb begin
        w_mul_sum  = {1'b0, acc_q} + (qr_q[0] ? {1'b0, m_q} : '0);
        w_div_sh   = {acc_q, qr_q[W-1]};
        w_div_diff = w_div_sh[W-1:0] - m_q;
        w_div_ge   = (w_div_sh >= {1'b0, m_q});
        w_is_div   = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        if (w_is_div) begin
            w_acc_n = w_div_ge ? w_div_diff : w_div_sh[W-1:0];
            w_qr_n  = {qr_q[W-2:0], w_div_ge};
        end else begin
            w_acc_n = w_mul_sum[W:1];
            w_qr_n  = {w_mul_sum[0], qr_q[W-1:1]};
        end
        w_prod     = {w_acc_n, w_qr_n};
        w_prod_fix = neg_q ? -w_prod : w_prod;
        result     = '0;
        case (op_q)
            OP_MUL:          result = w_qr_n;
            OP_MULH:         result = w_prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU: result = neg_q ? -w_qr_n : w_qr_n;
            OP_REM, OP_REMU: result = neg_q ? -w_acc_n : w_acc_n;
            default:         result = '0;
        endcase
    end

    // Operand load on start (magnitudes for signed ops), else advance a step
    always_comb begin
        acc_d    = acc_q;
        qr_d     = qr_q;
        m_d      = m_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        w_signed = op inside {OP_MULH, OP_DIV, OP_REM};
        w_a_neg  = w_signed & a[W-1];
        w_b_neg  = w_signed & b[W-1];
        w_mag_a  = w_a_neg ? -a : a;
        w_mag_b  = w_b_neg ? -b : b;
        if (start) begin
            cnt_d = '0;
            op_d  = op;
            acc_d = '0;
            if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
                qr_d = w_mag_a;
                m_d  = w_mag_b;
            end else begin
                qr_d = w_mag_b;
                m_d  = w_mag_a;
            end
            case (op)
                OP_MULH: neg_d = w_a_neg ^ w_b_neg;
                // Divide by zero keeps the all-ones quotient unsigned
                OP_DIV:  neg_d = (w_a_neg ^ w_b_neg) & (b != '0);
                OP_REM:  neg_d = w_a_neg;
                default: neg_d = 1'b0;
            endcase
        end else if (step) begin
            acc_d = w_acc_n;
            qr_d  = w_qr_n;
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Engine state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            qr_q  <= '0;
            m_q   <= '0;
            op_q  <= OP_ADD;
            neg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            qr_q  <= qr_d;
            m_q   <= m_d;
            op_q  <= op_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Handshaked multi-cycle ALU. Base ops complete in one cycle;
//               MUL/MULH/DIV/DIVU/REM/REMU iterate in seq_alu_divmul.
//               Define SEQ_ALU_FAST_MUL_EN for single-cycle MUL/MULH.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    alu_op_e               w_op;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0] w_base, w_eng_result;
    logic                  w_eng_start, w_eng_step, w_eng_last;

    assign w_op      = alu_op_e'(Operation);
    assign w_shamt   = SrcB[SHAMT_W-1:0];
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == EXEC);
    assign out_valid = (state_q == DONE);
    assign ALUResult = result_q;

`ifdef SEQ_ALU_FAST_MUL_EN
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    assign w_prod = $signed(SrcA) * $signed(SrcB);
`endif

    // Single-cycle result, taken from the live operands at accept
    always_comb begin
        w_base = '0;
        case (w_op)
            OP_ADD:  w_base = SrcA + SrcB;
            OP_SUB:  w_base = SrcA - SrcB;
            OP_AND:  w_base = SrcA & SrcB;
            OP_OR:   w_base = SrcA | SrcB;
            OP_XOR:  w_base = SrcA ^ SrcB;
            OP_SLL:  w_base = SrcA << w_shamt;
            OP_SRL:  w_base = SrcA >> w_shamt;
            OP_SRA:  w_base = $signed(SrcA) >>> w_shamt;
            OP_EQ:   w_base = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
            OP_SLT:  w_base = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
`ifdef SEQ_ALU_FAST_MUL_EN
            OP_MUL:  w_base = w_prod[DATA_WIDTH-1:0];
            OP_MULH: w_base = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
            default: w_base = '0;
        endcase
    end

    seq_alu_divmul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divmul (
        .clk    (clk),
        .reset  (reset),
        .start  (w_eng_start),
        .step   (w_eng_step),
        .op     (w_op),
        .a      (SrcA),
        .b      (SrcB),
        .last   (w_eng_last),
        .result (w_eng_result)
    );

    // Next-state and result capture; flush abandons EXEC/DONE only
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        w_eng_start = 1'b0;
        w_eng_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_iterative(w_op)) begin
                        w_eng_start = 1'b1;
                        state_d     = EXEC;
                    end else begin
                        result_d = w_base;
                        state_d  = DONE;
                    end
                end
            end
            EXEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    w_eng_step = 1'b1;
                    if (w_eng_last) begin
                        result_d = w_eng_result;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Scoreboard bench for seq_alu; expected results are queued at
//               issue and checked by an independent output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import seq_alu_pkg::*;

`ifdef SEQ_ALU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic [3:0]  Operation;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          c0;
        logic [3:0]  op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    seq_alu dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (busy) busy_cnt++;

    // Output monitor: pops one expectation per delivered result
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got %h, required no result", ALUResult);
            end else begin
                mon_e = sb_q.pop_front();
                if (ALUResult !== mon_e.res) begin
                    n_err++;
                    $display("FAIL result op=%b: got %h, required %h", mon_e.op, ALUResult, mon_e.res);
                end
                if (mon_e.lat >= 0) begin
                    n_vec++;
                    if (cyc - mon_e.c0 != mon_e.lat) begin
                        n_err++;
                        $display("FAIL latency op=%b: got %0d, required %0d", mon_e.op, cyc - mon_e.c0, mon_e.lat);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] exp, input int lat, input logic fl);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got in_ready=0, required 1");
        end
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        flush     = fl;
        if (push) sb_q.push_back('{exp, lat, cyc, op});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        issue(op, a, b, 1'b1, exp, lat, 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        SrcA = '0; SrcB = '0; Operation = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", ALUResult, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Base ops, latency 1
        run(OP_ADD, 32'd5, 32'd7, 32'd12, 1);
        run(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        run(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1);
        run(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1);
        run(OP_SLL, 32'd1, 32'd35, 32'd8, 1);
        run(OP_SRL, 32'h8000_0000, 32'h21, 32'h4000_0000, 1);
        run(OP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
        run(OP_EQ,  32'd9, 32'd9, 32'd1, 1);
        run(OP_EQ,  32'd9, 32'd8, 32'd0, 1);
        run(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
        drain();

        // Multiply, with busy duration
        busy_cnt = 0;
        run(OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MUL_LAT);
        drain();
        chk("mul_busy_cycles", busy_cnt, MUL_BUSY);
        run(OP_MULH, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, MUL_LAT);
        run(OP_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);
        drain();

        // Divide / remainder including zero divisor and overflow
        busy_cnt = 0;
        run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        drain();
        chk("div_busy_cycles", busy_cnt, 32);
        run(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run(OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, DIV_LAT);
        run(OP_REMU, 32'd7, 32'd0, 32'd7, DIV_LAT);
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
        run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_LAT);
        run(OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run(OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
        run(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, DIV_LAT);
        run(OP_DIV,  32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, DIV_LAT);
        run(OP_REM,  32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, DIV_LAT);
        drain();

        // Flush during EXEC: nothing may be delivered afterwards
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, -1, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_exec_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_exec_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_exec_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Flush held high in IDLE does not block the accept
        issue(OP_ADD, 32'd100, 32'd23, 1'b1, 32'd123, 1, 1'b1);
        drain();

        // Flush in DONE drops the pending result
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 1'b0, 32'd0, -1, 1'b0);
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_done_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);

        // Backpressure: result held, no new accept while stalled
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 32'hEDCB_5678, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            Operation = OP_ADD;
            SrcA      = 32'd1;
            SrcB      = 32'd2;
            in_valid  = 1'b1;
            chk("hold_result", ALUResult, 32'hEDCB_5678);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-operation
        issue(`ifdef SEQ_ALU_FAST_MUL_EN OP_DIV `else OP_MUL `endif, 32'd9, 32'd9, 1'b0, 32'd0, -1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_result", ALUResult, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after reset
        run(OP_SUB, 32'd50, 32'd8, 32'd42, 1);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
